if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues requests to instruction memory via a req/ready
//  handshake, and presents instruction + PC+4 to the IF/ID pipeline latch. Accepts redirects
//  (branch/jump) from EX and stalls (pc_write) from the hazard unit. One instruction per cycle
//  with zero-wait memory; tolerates arbitrary imem wait states.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction_out value when no valid instruction (bubble)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   asynchronous, active-low reset
//  pc_write         in   1   1 = advance; 0 = stall (hold PC and outputs)
//  pc_src           in   1   redirect request, single-cycle pulse
//  redirect_pc      in   32  redirect target, valid when pc_src=1
//  imem_req         out  1   memory request valid
//  imem_addr        out  32  request address, word aligned
//  imem_ready       in   1   memory accepts req and returns imem_rdata in the same cycle
//  imem_rdata       in   32  instruction word, valid when imem_req & imem_ready
//  instruction_out  out  32  fetched instruction to IF/ID
//  npc_out          out  32  address of instruction_out + 4
//  if_valid         out  1   instruction_out is a real instruction
//  misaligned_out   out  1   redirect target misaligned (MISALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (rst=0, async): pc=RESET_PC, state=IDLE, instruction_out=NOP_INSTR, npc_out=0,
//    if_valid=0, misaligned_out=0, skid empty. imem_req=0.
//  - States: IDLE, FETCH, HOLD, DRAIN. imem_req=1 in FETCH and DRAIN only; imem_addr=pc.
//  - IDLE: -> FETCH on first clk after reset release (first request one cycle after release).
//  - FETCH, handshake (req&ready), no redirect:
//      pc_write=1: instruction_out<=imem_rdata, npc_out<=pc+4, if_valid<=1, pc<=pc+4, stay FETCH
//                  (next request issued back-to-back, next cycle).
//      pc_write=0: imem_rdata, pc+4 -> skid; pc<=pc+4; -> HOLD; outputs unchanged.
//  - FETCH, no handshake: pc and imem_addr stable; if pc_write=1, if_valid<=0, instruction_out<=NOP.
//    if pc_write=0 outputs hold.
//  - HOLD: imem_req=0; when pc_write=1: skid -> outputs (if_valid=1), skid empty, -> FETCH.
//  - Redirect (pc_src=1) has priority over stall and over handshake data:
//      outputs flushed same edge (instruction_out=NOP_INSTR, if_valid=0, npc_out unchanged).
//      FETCH with handshake this cycle, or IDLE/HOLD: pc<=redirect_pc, skid cleared, -> FETCH.
//      FETCH without handshake: request outstanding; redirect_pc -> pending_pc; -> DRAIN.
//  - DRAIN: imem_req held at old pc until ready; data discarded; then pc<=pending_pc, -> FETCH.
//    A second pc_src in DRAIN overwrites pending_pc (latest wins).
//  - imem_addr must never change while imem_req=1 and imem_ready=0.
//  - PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000 (npc_out likewise).
//  - Reset mid-transaction: abandons request immediately; imem_req drops asynchronously.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 is not taken; pc unchanged,
//    outputs flushed, misaligned_out=1 for one cycle, state -> IDLE until next redirect.
//    Resumes (redirect_pc aligned) normally.
//  Not defined: misaligned_out tied 0; redirect_pc[1:0] ignored (forced to 2'b00).
// TESTING
//  1 Reset, imem_ready=1, pc_write=1: addrs 0,4,8 on consecutive cycles; npc_out 4,8,12; if_valid=1.
//  2 imem_ready low 3 cycles at addr 8: imem_addr stable 8, if_valid=0, then instr@8, npc_out=12.
//  3 pc_write=0 at handshake of addr 4: HOLD, imem_req=0, outputs frozen; release -> instr@4, then
//    request addr 8.
//  4 pc_src=1, redirect_pc=0x100 while addr 0x10 pending (ready low): DRAIN, data discarded,
//    next request 0x100, if_valid=0 until 0x100 returns with npc_out=0x104.
//  5 RESET_PC=32'hFFFF_FFFC: first npc_out=0, next imem_addr=0; rst low mid-request -> imem_req=0
//    immediately, pc=RESET_PC.
//  6 MISALIGN_CHECK_EN: redirect_pc=0x102 -> misaligned_out=1 one cycle, no request to 0x102,
//    if_valid=0; without macro -> request 0x100.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC owner, imem req/ready master, IF/ID output latch with one-entry skid.
// Optional build macro MISALIGN_CHECK_EN rejects redirects to non-word-aligned targets.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        pc_src,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] npc_out,
    output logic        if_valid,
    output logic        misaligned_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_DRAIN} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_req, w_req_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_npc, w_npc_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_skid_instr, w_skid_instr_nxt;
    logic [31:0] r_skid_npc, w_skid_npc_nxt;
    logic [31:0] r_pend, w_pend_nxt;
    logic        w_hs;
    logic [31:0] w_pc_inc;
    logic [31:0] w_redir;
`ifdef MISALIGN_CHECK_EN
    logic        r_mis, w_mis_nxt;
    logic        r_halt, w_halt_nxt;
`endif

    assign w_hs     = r_req & imem_ready;
    assign w_pc_inc = r_pc + 32'd4;
`ifdef MISALIGN_CHECK_EN
    assign w_redir  = redirect_pc;
`else
    assign w_redir  = redirect_pc & ~32'd3;
`endif

    // Next-state and next-value logic; redirect outranks stall and returning data
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_instr_nxt      = r_instr;
        w_npc_nxt        = r_npc;
        w_valid_nxt      = r_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_npc_nxt   = r_skid_npc;
        w_pend_nxt       = r_pend;
`ifdef MISALIGN_CHECK_EN
        w_mis_nxt        = 1'b0;
        w_halt_nxt       = r_halt;
`endif
        if (pc_src) begin
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
`ifdef MISALIGN_CHECK_EN
            if (w_redir[1:0] != 2'b00) begin
                w_mis_nxt   = 1'b1;
                w_halt_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end else
`endif
            if ((r_state == ST_FETCH || r_state == ST_DRAIN) && !w_hs) begin
                // Outstanding request must complete at its original address first
                w_pend_nxt  = w_redir;
                w_state_nxt = ST_DRAIN;
            end else begin
                w_pc_nxt    = w_redir;
                w_state_nxt = ST_FETCH;
`ifdef MISALIGN_CHECK_EN
                w_halt_nxt  = 1'b0;
`endif
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef MISALIGN_CHECK_EN
                    if (!r_halt)
`endif
                    w_state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_hs) begin
                        w_pc_nxt = w_pc_inc;
                        if (pc_write) begin
                            w_instr_nxt = imem_rdata;
                            w_npc_nxt   = w_pc_inc;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_skid_instr_nxt = imem_rdata;
                            w_skid_npc_nxt   = w_pc_inc;
                            w_state_nxt      = ST_HOLD;
                        end
                    end else if (pc_write) begin
                        w_instr_nxt = NOP_INSTR;
                        w_valid_nxt = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (pc_write) begin
                        w_instr_nxt = r_skid_instr;
                        w_npc_nxt   = r_skid_npc;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ready) begin
                        w_pc_nxt    = r_pend;
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        w_req_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_req        <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_npc        <= '0;
            r_valid      <= 1'b0;
            r_skid_instr <= '0;
            r_skid_npc   <= '0;
            r_pend       <= '0;
`ifdef MISALIGN_CHECK_EN
            r_mis        <= 1'b0;
            r_halt       <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_req        <= w_req_nxt;
            r_instr      <= w_instr_nxt;
            r_npc        <= w_npc_nxt;
            r_valid      <= w_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_npc   <= w_skid_npc_nxt;
            r_pend       <= w_pend_nxt;
`ifdef MISALIGN_CHECK_EN
            r_mis        <= w_mis_nxt;
            r_halt       <= w_halt_nxt;
`endif
        end
    end

    assign imem_req        = r_req;
    assign imem_addr       = r_pc;
    assign instruction_out = r_instr;
    assign npc_out         = r_npc;
    assign if_valid        = r_valid;
`ifdef MISALIGN_CHECK_EN
    assign misaligned_out  = r_mis;
`else
    assign misaligned_out  = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios, then random traffic against a fetch-stream model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        pc_src;
    logic [31:0] redirect_pc;
    logic        imem_ready;

    logic        req0, valid0, mis0;
    logic [31:0] addr0, rdata0, instr0, npc0;
    logic        req5, valid5, mis5;
    logic [31:0] addr5, rdata5, instr5, npc5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign rdata0 = mem_word(addr0);
    assign rdata5 = mem_word(addr5);

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .pc_src(pc_src), .redirect_pc(redirect_pc),
        .imem_req(req0), .imem_addr(addr0), .imem_ready(imem_ready), .imem_rdata(rdata0),
        .instruction_out(instr0), .npc_out(npc0), .if_valid(valid0), .misaligned_out(mis0)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_dut5 (
        .clk(clk), .rst(rst), .pc_write(pc_write), .pc_src(pc_src), .redirect_pc(redirect_pc),
        .imem_req(req5), .imem_addr(addr5), .imem_ready(imem_ready), .imem_rdata(rdata5),
        .instruction_out(instr5), .npc_out(npc5), .if_valid(valid5), .misaligned_out(mis5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset both instances, check reset values, release mid-cycle
    task automatic do_reset();
        rst = 1'b0; pc_src = 1'b0; pc_write = 1'b1; imem_ready = 1'b1; redirect_pc = '0;
        tick(); tick();
        chk1("rst_req", req0, 1'b0);
        chk1("rst_valid", valid0, 1'b0);
        chk("rst_instr", instr0, NOP);
        chk("rst_npc", npc0, 32'h0);
        chk1("rst_mis", mis0, 1'b0);
        chk("rst_addr", addr0, 32'h0);
        chk("rst_addr5", addr5, 32'hFFFF_FFFC);
        chk1("rst_mis5", mis5, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        logic        p_req, p_ready, p_pcw, p_src, p_valid;
        logic [31:0] p_addr, p_redir, p_instr, p_npc;
        logic [31:0] exp_npc;
        int          deliveries;

        // Back-to-back fetch then three wait states at address 8
        do_reset();
        tick();
        chk1("t1_req", req0, 1'b1);
        chk("t1_addr0", addr0, 32'h0);
        tick();
        chk("t1_addr4", addr0, 32'h4);
        chk("t1_npc4", npc0, 32'h4);
        chk1("t1_valid", valid0, 1'b1);
        tick();
        chk("t1_addr8", addr0, 32'h8);
        chk("t1_npc8", npc0, 32'h8);
        chk("t1_instr4", instr0, mem_word(32'h4));
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_addr_stable", addr0, 32'h8);
            chk1("t2_req", req0, 1'b1);
            chk1("t2_bubble", valid0, 1'b0);
            chk("t2_nop", instr0, NOP);
        end
        imem_ready = 1'b1;
        tick();
        chk("t2_instr8", instr0, mem_word(32'h8));
        chk("t2_npc12", npc0, 32'hC);
        chk1("t2_valid", valid0, 1'b1);

        // Stall at the handshake of address 4
        do_reset();
        tick();
        tick();
        pc_write = 1'b0;
        tick();
        chk1("t3_hold_req", req0, 1'b0);
        chk("t3_frozen_instr", instr0, mem_word(32'h0));
        chk("t3_frozen_npc", npc0, 32'h4);
        tick();
        chk1("t3_hold_req2", req0, 1'b0);
        chk1("t3_frozen_valid", valid0, 1'b1);
        pc_write = 1'b1;
        tick();
        chk("t3_instr4", instr0, mem_word(32'h4));
        chk("t3_npc8", npc0, 32'h8);
        chk1("t3_req", req0, 1'b1);
        chk("t3_addr8", addr0, 32'h8);

        // Redirect while 0x10 is outstanding
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("t4_addr10", addr0, 32'h10);
        imem_ready = 1'b0; pc_src = 1'b1; redirect_pc = 32'h100;
        tick();
        pc_src = 1'b0;
        chk1("t4_flush", valid0, 1'b0);
        chk("t4_drain_addr", addr0, 32'h10);
        chk1("t4_drain_req", req0, 1'b1);
        tick();
        chk("t4_drain_addr2", addr0, 32'h10);
        imem_ready = 1'b1;
        tick();
        chk("t4_addr100", addr0, 32'h100);
        chk1("t4_still_bubble", valid0, 1'b0);
        tick();
        chk("t4_instr100", instr0, mem_word(32'h100));
        chk("t4_npc104", npc0, 32'h104);
        chk1("t4_valid", valid0, 1'b1);

        // PC wrap and asynchronous reset mid-request
        do_reset();
        tick();
        chk("t5_addr_top", addr5, 32'hFFFF_FFFC);
        tick();
        chk("t5_npc_wrap", npc5, 32'h0);
        chk("t5_instr_top", instr5, mem_word(32'hFFFF_FFFC));
        chk1("t5_valid", valid5, 1'b1);
        chk("t5_addr_wrap", addr5, 32'h0);
        imem_ready = 1'b0;
        tick();
        chk1("t5_req_pending", req5, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("t5_async_req", req5, 1'b0);
        chk("t5_async_pc", addr5, 32'hFFFF_FFFC);

        // Redirect to a misaligned target
        do_reset();
        tick();
        pc_src = 1'b1; redirect_pc = 32'h102;
        tick();
        pc_src = 1'b0;
        chk1("t6_valid", valid0, 1'b0);
`ifdef MISALIGN_CHECK_EN
        chk1("t6_mis", mis0, 1'b1);
        chk1("t6_no_req", req0, 1'b0);
        tick();
        chk1("t6_mis_pulse", mis0, 1'b0);
        chk1("t6_idle", req0, 1'b0);
`else
        chk1("t6_mis", mis0, 1'b0);
        chk("t6_addr100", addr0, 32'h100);
        chk1("t6_req", req0, 1'b1);
`endif

        // Random traffic: every delivered word must continue the program-order stream
        do_reset();
        exp_npc = 32'h4;
        deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            imem_ready  = ($urandom_range(0, 9) < 7);
            pc_write    = ($urandom_range(0, 3) != 0);
            pc_src      = ($urandom_range(0, 19) == 0);
            redirect_pc = 32'($urandom_range(0, 255)) << 2;
            p_req = req0; p_addr = addr0; p_ready = imem_ready; p_pcw = pc_write;
            p_src = pc_src; p_redir = redirect_pc;
            p_valid = valid0; p_instr = instr0; p_npc = npc0;
            tick();
            if (p_req && !p_ready) begin
                chk1("r_req_held", req0, 1'b1);
                chk("r_addr_held", addr0, p_addr);
            end
            if (p_src) begin
                chk1("r_flush_valid", valid0, 1'b0);
                chk("r_flush_instr", instr0, NOP);
                chk("r_flush_npc", npc0, p_npc);
                exp_npc = p_redir + 32'd4;
            end else if (!p_pcw) begin
                chk1("r_stall_valid", valid0, p_valid);
                chk("r_stall_instr", instr0, p_instr);
                chk("r_stall_npc", npc0, p_npc);
            end else if (valid0) begin
                chk("r_stream_npc", npc0, exp_npc);
                chk("r_stream_instr", instr0, mem_word(exp_npc - 32'd4));
                exp_npc = exp_npc + 32'd4;
                deliveries++;
            end else begin
                chk("r_bubble_instr", instr0, NOP);
            end
        end
        chk1("r_progress", (deliveries > 300), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
